// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts byte-addressed load/store requests into word accesses on a
//   word-addressed data memory. Loads are lane-selected and sign/zero
//   extended. Byte/half stores use a read-modify-write pass. Misaligned,
//   reserved-size and out-of-range requests fault without touching memory.
//
// Ports
//   clock, reset_n                 clock / async active-low reset
//   reqValid/reqReady              request handshake (ready in IDLE only)
//   reqWrite, reqSize, reqUnsigned request kind, size (00 B, 01 H, 10 W), extension
//   reqAddr, reqWData              byte address, right-aligned store data
//   respValid/respReady            response handshake
//   respRData, respFault           extended load data, fault flag
//   memAddress, memWriteData       word index and write word to memory
//   memWrite, memRead              memory strobes (never both set)
//   memReadData                    combinational memory read data

// One byte lane of the read-modify-write merge.
module lsu_lane (
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    input  logic       sel,
    output logic [7:0] merged
);
    assign merged = sel ? new_byte : old_byte;
endmodule

module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respRData,
    output logic        respFault,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData
);
    localparam int          NUM_LANES = 4;
    localparam logic [31:0] WORDS_LIM = 32'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic        fault_q;
    logic [31:0] rdata_q;   // extended load result (0 for stores/faults)
    logic [31:0] word_q;    // store data at accept, merged word after READ

    logic        accept, fault_in;
    logic [31:0] shifted, load_ext, rep, merged;
    logic [NUM_LANES-1:0] be;

    assign accept   = reqValid & reqReady;
    assign fault_in = (reqSize == 2'b11)
                    | ((reqSize == 2'b01) & reqAddr[0])
                    | ((reqSize == 2'b10) & (|reqAddr[1:0]))
                    | ({2'b00, reqAddr[31:2]} >= WORDS_LIM);

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign shifted = memReadData >> {req_q.addr[1:0], 3'b000};
    always_comb begin
        load_ext = shifted;
        case (req_q.size)
            2'b00: load_ext = req_q.uns ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = req_q.uns ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Store path: replicate the store data across lanes and pick with byte enables.
    assign rep = (req_q.size == 2'b00) ? {4{word_q[7:0]}} : {2{word_q[15:0]}};
    always_comb begin
        be = 4'b1111;
        case (req_q.size)
            2'b00:   be = 4'b0001 << req_q.addr[1:0];
            2'b01:   be = req_q.addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lsu_lane u_lane (
            .old_byte (memReadData[8*g +: 8]),
            .new_byte (rep[8*g +: 8]),
            .sel      (be[g]),
            .merged   (merged[8*g +: 8])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            word_q  <= '0;
        end else if (accept) begin
            req_q   <= '{write: reqWrite, size: reqSize, uns: reqUnsigned, addr: reqAddr};
            fault_q <= fault_in;
            rdata_q <= '0;
            word_q  <= reqWData;
        end else if (state == READ) begin
            if (req_q.write) word_q  <= merged;
            else             rdata_q <= load_ext;
        end
    end

    always_comb begin
        state_nxt    = state;
        reqReady     = 1'b0;
        respValid    = 1'b0;
        respRData    = '0;
        respFault    = 1'b0;
        memAddress   = '0;
        memWriteData = '0;
        memWrite     = 1'b0;
        memRead      = 1'b0;
        case (state)
            IDLE: begin
                reqReady = reset_n;
                if (accept) begin
                    if (fault_in)                               state_nxt = RESP;
                    else if (reqWrite && (reqSize == 2'b10))    state_nxt = WRITE;
                    else                                        state_nxt = READ;
                end
            end
            READ: begin
                memRead    = reset_n;
                memAddress = {2'b00, req_q.addr[31:2]};
                state_nxt  = req_q.write ? WRITE : RESP;
            end
            WRITE: begin
                // Gated with reset_n so a reset never lets a write commit.
                memWrite     = reset_n;
                memAddress   = {2'b00, req_q.addr[31:2]};
                memWriteData = word_q;
                state_nxt    = RESP;
            end
            RESP: begin
                respValid = reset_n;
                respRData = rdata_q;
                respFault = fault_q;
                if (respReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
